// File: rtl/prior_cov_pkg.sv
// Shared definitions for the prior-covariance engine S = A*P*A^T + Q.
// Optional build macro PRIOR_COV_SAT_EN: when defined, the N-bit narrowing
// saturates on overflow instead of wrapping. Overflow is flagged either way.
package prior_cov_pkg;

  // FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PH_T = 2'd1;
  localparam logic [1:0] PH_S = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Working width for the narrowing helper; wide enough for any legal N/DIM
  localparam int WIDE_W = 128;

  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } trunc_t;

  // Accumulator width: full 2N-bit products plus growth for DIM terms
  function automatic int acc_w(input int n, input int dim);
    return 2 * n + $clog2(dim);
  endfunction

  // Row-major flat element index
  function automatic int idx(input int i, input int j, input int dim);
    return i * dim + j;
  endfunction

  // Narrow a wide fixed-point value to bits [frac+n-1:frac]; flag out-of-range
  function automatic trunc_t trunc_sat(input logic signed [WIDE_W-1:0] x,
                                       input int n, input int frac);
    logic signed [WIDE_W-1:0] sh;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    trunc_t r;
    sh       = x >>> frac;
    hi       = '0;
    hi[n-1]  = 1'b1;
    hi       = hi - 128'sd1;
    lo       = -hi - 128'sd1;
    r.ovf    = (sh > hi) || (sh < lo);
    r.val    = sh[63:0];
`ifdef PRIOR_COV_SAT_EN
    if (sh > hi) r.val = hi[63:0];
    else if (sh < lo) r.val = lo[63:0];
`endif
    return r;
  endfunction

endpackage

// File: rtl/prior_cov_gen_dot.sv
// Combinational DIM-lane signed dot product with a wide addend, narrowed to
// N bits with an overflow flag. Shared by both phases of prior_cov_gen.
module prior_cov_dot
  import prior_cov_pkg::*;
#(
  parameter int N    = 20,
  parameter int FRAC = 10,
  parameter int DIM  = 2
) (
  input  logic [DIM*N-1:0]                x_flat,
  input  logic [DIM*N-1:0]                y_flat,
  input  logic signed [acc_w(N,DIM)-1:0]  addend,
  output logic [N-1:0]                    res,
  output logic                            ovf
);

  localparam int AW = acc_w(N, DIM);

  logic signed [2*N-1:0]    prod [DIM];
  logic signed [AW-1:0]     acc;
  logic signed [WIDE_W-1:0] acc_wide;
  trunc_t                   tr;
  logic                     unused_hi;

  // Full-precision products summed with the addend, then narrowed
  always_comb begin
    acc = addend;
    for (int k = 0; k < DIM; k++) begin
      prod[k] = $signed(x_flat[k*N +: N]) * $signed(y_flat[k*N +: N]);
      acc     = acc + {{(AW-2*N){prod[k][2*N-1]}}, prod[k]};
    end
    acc_wide = {{(WIDE_W-AW){acc[AW-1]}}, acc};
    tr       = trunc_sat(acc_wide, N, FRAC);
  end

  assign res       = tr.val[N-1:0];
  assign ovf       = tr.ovf;
  assign unused_hi = ^tr.val[63:N];

endmodule

// File: rtl/prior_cov_gen.sv
// Kalman prior-covariance engine S = A*P*A^T + Q for DIM x DIM fixed point.
// PH_T computes T = P*A^T, PH_S computes S = A*T + Q, one element per cycle
// through a single shared dot-product datapath.
// Handshake: start is sampled only in IDLE or DONE; an accepted start
// captures A/P/Q, busy is high for the 2*DIM^2 compute cycles, and done is a
// one-cycle pulse in the cycle after the last S element is written. start
// while busy is dropped.
// Optional build macro PRIOR_COV_SAT_EN selects saturating narrowing.
module prior_cov_gen
  import prior_cov_pkg::*;
#(
  parameter int N    = 20,
  parameter int FRAC = 10,
  parameter int DIM  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM*DIM*N-1:0]  a_flat,
  input  logic [DIM*DIM*N-1:0]  p_flat,
  input  logic [DIM*DIM*N-1:0]  q_flat,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [DIM*DIM*N-1:0]  p_prior_flat,
  output logic [1:0]            state_dbg
);

  localparam int AW = acc_w(N, DIM);

  if (DIM < 2 || DIM > 4) begin : g_dim_chk
    $fatal(1, "prior_cov_gen: DIM must be in 2..4");
  end

  logic [1:0]             state;
  logic [DIM*DIM*N-1:0]   a_r, p_r, q_r, t_r;
  logic [1:0]             i_r, j_r;
  logic [DIM*N-1:0]       x_vec, y_vec;
  logic signed [AW-1:0]   addend;
  logic [N-1:0]           dot_res;
  logic                   dot_ovf;
  logic                   last_el;
  int                     cur;

  assign last_el   = (i_r == 2'(DIM-1)) && (j_r == 2'(DIM-1));
  assign cur       = idx(int'(i_r), int'(j_r), DIM);
  assign busy      = (state == PH_T) || (state == PH_S);
  assign done      = (state == DONE);
  assign state_dbg = state;

  // Route operands: PH_T uses row i of P with row j of A; PH_S uses row i of
  // A with column j of T plus Q[i][j] aligned to the product scale
  always_comb begin
    x_vec  = '0;
    y_vec  = '0;
    addend = '0;
    for (int k = 0; k < DIM; k++) begin
      if (state == PH_S) begin
        x_vec[k*N +: N] = a_r[idx(int'(i_r), k, DIM)*N +: N];
        y_vec[k*N +: N] = t_r[idx(k, int'(j_r), DIM)*N +: N];
      end else begin
        x_vec[k*N +: N] = p_r[idx(int'(i_r), k, DIM)*N +: N];
        y_vec[k*N +: N] = a_r[idx(int'(j_r), k, DIM)*N +: N];
      end
    end
    if (state == PH_S) begin
      addend = {{(AW-N){q_r[cur*N+N-1]}}, q_r[cur*N +: N]} <<< FRAC;
    end
  end

  prior_cov_dot #(.N(N), .FRAC(FRAC), .DIM(DIM)) u_dot (
    .x_flat (x_vec),
    .y_flat (y_vec),
    .addend (addend),
    .res    (dot_res),
    .ovf    (dot_ovf)
  );

  // FSM, operand capture, element counters and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_r          <= '0;
      p_r          <= '0;
      q_r          <= '0;
      t_r          <= '0;
      i_r          <= '0;
      j_r          <= '0;
      ovf          <= 1'b0;
      p_prior_flat <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r   <= a_flat;
            p_r   <= p_flat;
            q_r   <= q_flat;
            ovf   <= 1'b0;
            i_r   <= '0;
            j_r   <= '0;
            state <= PH_T;
          end else begin
            state <= IDLE;
          end
        end
        PH_T, PH_S: begin
          if (state == PH_T) t_r[cur*N +: N] <= dot_res;
          else               p_prior_flat[cur*N +: N] <= dot_res;
          if (dot_ovf) ovf <= 1'b1;
          if (j_r == 2'(DIM-1)) begin
            j_r <= '0;
            i_r <= last_el ? 2'd0 : i_r + 2'd1;
          end else begin
            j_r <= j_r + 2'd1;
          end
          if (last_el) state <= (state == PH_T) ? PH_S : DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prior_cov_gen.sv
// Bench for prior_cov_gen: DIM=2 and DIM=3 instances checked against a
// matrix-arithmetic reference model. Honours PRIOR_COV_SAT_EN like the RTL.
module tb_prior_cov_gen;

  localparam int N    = 20;
  localparam int FRAC = 10;
  localparam int E2   = 4 * N;
  localparam int E3   = 9 * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start2 = 1'b0, start3 = 1'b0;
  logic [E2-1:0] a2 = '0, p2 = '0, q2 = '0, s2;
  logic [E3-1:0] a3 = '0, p3 = '0, q3 = '0, s3;
  logic          busy2, done2, ovf2, busy3, done3, ovf3;
  logic [1:0]    st2, st3;

  prior_cov_gen #(.N(N), .FRAC(FRAC), .DIM(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_flat(a2), .p_flat(p2),
    .q_flat(q2), .busy(busy2), .done(done2), .ovf(ovf2),
    .p_prior_flat(s2), .state_dbg(st2));

  prior_cov_gen #(.N(N), .FRAC(FRAC), .DIM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_flat(a3), .p_flat(p3),
    .q_flat(q3), .busy(busy3), .done(done3), .ovf(ovf3),
    .p_prior_flat(s3), .state_dbg(st3));

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [N-1:0]  exp_q[$];

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int     ma[16], mp[16], mq[16];
  longint ms[16];
  bit     m_ovf;

  function automatic longint mtrunc(input longint x, inout bit ov);
    longint sh, maxv, minv, w;
    sh   = x >>> FRAC;
    maxv = (64'sd1 <<< (N-1)) - 1;
    minv = -maxv - 1;
    if (sh > maxv || sh < minv) ov = 1'b1;
`ifdef PRIOR_COV_SAT_EN
    if (sh > maxv) return maxv;
    if (sh < minv) return minv;
`endif
    w = sh & ((64'sd1 <<< N) - 1);
    if (w > maxv) w = w - (64'sd1 <<< N);
    return w;
  endfunction

  // T = P*A^T, S = A*T + Q, each element narrowed
  task automatic model(input int dim);
    longint t[16];
    longint acc;
    m_ovf = 1'b0;
    for (int i = 0; i < dim; i++)
      for (int j = 0; j < dim; j++) begin
        acc = 0;
        for (int k = 0; k < dim; k++)
          acc += longint'(mp[i*dim+k]) * longint'(ma[j*dim+k]);
        t[i*dim+j] = mtrunc(acc, m_ovf);
      end
    for (int i = 0; i < dim; i++)
      for (int j = 0; j < dim; j++) begin
        acc = longint'(mq[i*dim+j]) * (64'sd1 <<< FRAC);
        for (int k = 0; k < dim; k++)
          acc += longint'(ma[i*dim+k]) * t[k*dim+j];
        ms[i*dim+j] = mtrunc(acc, m_ovf);
      end
  endtask

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  task automatic set_mats(input int dim, input int av, input int pv, input int qv);
    for (int e = 0; e < 16; e++) begin
      ma[e] = 0; mp[e] = 0; mq[e] = 0;
    end
    for (int d = 0; d < dim; d++) begin
      ma[d*dim+d] = av; mp[d*dim+d] = pv; mq[d*dim+d] = qv;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic launch2();
    for (int e = 0; e < 4; e++) begin
      a2[e*N +: N] = ma[e][N-1:0];
      p2[e*N +: N] = mp[e][N-1:0];
      q2[e*N +: N] = mq[e][N-1:0];
    end
    start2 = 1'b1;
  endtask

  task automatic launch3();
    for (int e = 0; e < 9; e++) begin
      a3[e*N +: N] = ma[e][N-1:0];
      p3[e*N +: N] = mp[e][N-1:0];
      q3[e*N +: N] = mq[e][N-1:0];
    end
    start3 = 1'b1;
  endtask

  // Called at the negedge of the accept cycle; returns at the negedge where
  // done is seen. lat counts cycles after accept (0 = timed out).
  task automatic wait_done2(input int poke, output int lat);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start2 = (c == poke);
      if (c == 2) begin a2 = ~a2; p2 = ~p2; q2 = ~q2; end
      if (done2) begin lat = c; break; end
    end
    start2 = 1'b0;
  endtask

  task automatic wait_done3(output int lat);
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (c == 1) begin a3 = {E3{1'b1}}; p3 = '0; end
      if (done3) begin lat = c; break; end
    end
  endtask

  task automatic compare2(input string tag);
    logic [N-1:0] e;
    model(2);
    for (int k = 0; k < 4; k++) exp_q.push_back(ms[k][N-1:0]);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_s%0d", tag, k), longint'($signed(s2[k*N +: N])),
            longint'($signed(e)));
    end
    check({tag, "_ovf"}, 64'(ovf2), 64'(m_ovf));
  endtask

  task automatic compare3(input string tag);
    logic [N-1:0] e;
    model(3);
    for (int k = 0; k < 9; k++) exp_q.push_back(ms[k][N-1:0]);
    for (int k = 0; k < 9; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_s%0d", tag, k), longint'($signed(s3[k*N +: N])),
            longint'($signed(e)));
    end
    check({tag, "_ovf"}, 64'(ovf3), 64'(m_ovf));
  endtask

  task automatic set_t1();
    set_mats(2, 1024, 0, 10);
    mp[0] = 2048; mp[1] = 512; mp[2] = 512; mp[3] = 1024;
  endtask

  // ---------------- test sequence ----------------
  int lat;
  int done_cnt;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy2), 64'd0);
    check("rst_done", 64'(done2), 64'd0);
    check("rst_ovf", 64'(ovf2), 64'd0);
    check("rst_s2_zero", 64'(s2 != '0), 64'd0);
    check("rst_s3_zero", 64'(s3 != '0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: A=I, P=[2048,512;512,1024], Q=10*I
    set_t1();
    launch2();
    wait_done2(0, lat);
    check("t1_latency", 64'(lat), 64'd9);
    check("t1_s00_lit", longint'($signed(s2[0 +: N])), 64'sd2058);
    check("t1_s11_lit", longint'($signed(s2[3*N +: N])), 64'sd1034);
    compare2("t1");

    // Test 2: A=[1024,1024;0,1024], P=I, Q=0
    @(negedge clk);
    set_mats(2, 1024, 1024, 0);
    ma[1] = 1024;
    launch2();
    wait_done2(0, lat);
    check("t2_latency", 64'(lat), 64'd9);
    check("t2_s01_lit", longint'($signed(s2[N +: N])), 64'sd1024);
    compare2("t2");

    // Test 3: S overflows while T does not
    @(negedge clk);
    set_mats(2, 16384, 4096, 0);
    launch2();
    wait_done2(0, lat);
    check("t3_latency", 64'(lat), 64'd9);
`ifdef PRIOR_COV_SAT_EN
    check("t3_s00_lit", longint'($signed(s2[0 +: N])), 64'sd524287);
`else
    check("t3_s00_lit", longint'($signed(s2[0 +: N])), 64'sd0);
`endif
    check("t3_ovf_lit", 64'(ovf2), 64'd1);
    compare2("t3");

    // Test 4: start while busy is ignored; start on the done cycle chains
    @(negedge clk);
    set_t1();
    launch2();
    wait_done2(3, lat);
    check("t4_latency_a", 64'(lat), 64'd9);
    compare2("t4a");
    set_mats(2, 1024, 1024, 10);
    launch2();
    wait_done2(0, lat);
    check("t4_latency_b", 64'(lat), 64'd9);
    compare2("t4b");

    // Test 5: reset during PH_S, with ovf already raised
    @(negedge clk);
    set_mats(2, 16384, 4096, 0);
    launch2();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start2 = 1'b0;
    end
    check("t5_busy_before", 64'(busy2), 64'd1);
    check("t5_ovf_before", 64'(ovf2), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_busy", 64'(busy2), 64'd0);
    check("t5_done", 64'(done2), 64'd0);
    check("t5_ovf", 64'(ovf2), 64'd0);
    check("t5_s_zero", 64'(s2 != '0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done2) done_cnt++;
    end
    check("t5_no_done", 64'(done_cnt), 64'd0);
    set_t1();
    launch2();
    wait_done2(0, lat);
    check("t5_latency", 64'(lat), 64'd9);
    compare2("t5");

    // Random DIM=2 runs, mixing small and full-range operands
    for (int r = 0; r < 6; r++) begin
      int lim;
      @(negedge clk);
      lim = (r % 2 == 0) ? 2048 : (1 << (N-1)) - 1;
      for (int e = 0; e < 16; e++) begin
        ma[e] = rnd(-lim, lim); mp[e] = rnd(-lim, lim); mq[e] = rnd(-lim, lim);
      end
      launch2();
      wait_done2(0, lat);
      check($sformatf("r%0d_latency", r), 64'(lat), 64'd9);
      compare2($sformatf("r%0d", r));
    end

    // Test 6: DIM=3, A=I, random P and Q
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      set_mats(3, 1024, 0, 0);
      for (int e = 0; e < 9; e++) begin
        mp[e] = rnd(-16384, 16384);
        mq[e] = rnd(-16384, 16384);
      end
      launch3();
      wait_done3(lat);
      check($sformatf("d3_%0d_latency", r), 64'(lat), 64'd19);
      check($sformatf("d3_%0d_s00_sum", r), longint'($signed(s3[0 +: N])),
            64'(mp[0] + mq[0]));
      compare3($sformatf("d3_%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prior_cov_gen.md
Name: prior_cov_gen

Overview:
Parametrised Kalman prior-covariance engine that computes S = A*P*A^T + Q for DIM x DIM fixed-point matrices. It is the generalised successor of the 2x2 semi-parallel prior-covariance block. It is built from one DIM-wide dot-product datapath that is time-multiplexed over two phases and uses a start/busy/done handshake. It sits between the state-predict stage and the Kalman-gain stage of the filter core.

Parameters:
N, 20, data word width (signed, two's complement)
FRAC, 10, fractional bits (Q(N-FRAC).FRAC)
DIM, 2, matrix dimension; legal 2..4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  request; accepted only in IDLE or DONE
a_flat  in  DIM*DIM*N  A, row-major; element (i,j) at [(i*DIM+j)*N +: N]
p_flat  in  DIM*DIM*N  P, same packing
q_flat  in  DIM*DIM*N  Q, same packing
busy  out  1  high in PH_T and PH_S
done  out  1  one-cycle pulse when S is valid
ovf  out  1  sticky; set if any truncation to N bits exceeded range during this run
p_prior_flat  out  DIM*DIM*N  S, same packing; held until the next accepted start completes an element write

Behaviour:
- Reset: async clear of all state. FSM goes to IDLE. busy=0, done=0, ovf=0, p_prior_flat=0, internal A/P/Q/T copies=0, counters=0.
- FSM states:
  - IDLE: on start go to PH_T.
  - PH_T: DIM^2 cycles, then go to PH_S.
  - PH_S: DIM^2 cycles, then go to DONE.
  - DONE: one cycle. If start is high, go to PH_T; otherwise go to IDLE.
- Accept cycle: a_flat, p_flat and q_flat are captured into internal registers. Callers may change the inputs afterwards. ovf is cleared. Element counters (i,j) are reset to (0,0).
- start while busy is ignored; it is neither queued nor allowed to affect the run.
- PH_T, one element per cycle in row-major order:
  - T[i][j] = trunc(sum_k P[i][k]*A[j][k]), i.e. T = P*A^T.
  - The DIM products are full 2N-bit values. The sum uses an accumulator of width 2N+clog2(DIM).
  - The sum and truncation are combinational; T[i][j] is registered at the end of the cycle.
- PH_S, one element per cycle in row-major order:
  - S[i][j] = trunc(sum_k A[i][k]*T[k][j] + (Q[i][j] sign-extended <<< FRAC)).
  - The add happens in the wide domain; the result is written to p_prior_flat at the end of the cycle.
- trunc(x): take bits [FRAC+N-1:FRAC] of x. Overflow means that x>>>FRAC is outside [-2^(N-1), 2^(N-1)-1]. Overflow in either phase sets ovf.
- Latency: the accept cycle is C0 and done=1 in cycle C(2*DIM^2+1). For DIM=2 this is cycle 9.
- p_prior_flat elements update progressively during PH_S. They are valid as a set only at done and stay stable until the next run's PH_S.
- Reset mid-run: immediate return to IDLE with all outputs 0. No done pulse is produced.
- DIM outside 2..4 is a generate-time fatal error.

Optional Feature:
- Macro PRIOR_COV_SAT_EN.
- Defined: trunc saturates to 2^(N-1)-1 or -2^(N-1) on overflow. This applies to T and S.
- Undefined: plain bit-slice wrap.
- ovf is reported identically in both cases.

Decomposition:
- Shared package prior_cov_pkg holds:
  - the width function ACC_W(N,DIM)=2N+clog2(DIM);
  - the saturate/truncate function;
  - the flat-index function idx(i,j,DIM);
  - FSM state encoding IDLE/PH_T/PH_S/DONE.
- One sub-module, prior_cov_dot: a combinational DIM-lane signed dot product with an optional wide addend. It outputs the truncated N-bit result and an overflow flag, and is instantiated once.

Test Plan:
1. DIM=2, A=I(1024), P=[2048,512;512,1024], Q=[10,0;0,10] -> S=[2058,512;512,1034], done exactly 9 cycles after accept, ovf=0.
2. DIM=2, A=[1024,1024;0,1024], P=I(1024), Q=0 -> S=[2048,1024;1024,1024].
3. DIM=2, A=diag(16384), P=diag(4096), Q=0 -> T00=65536 with no overflow.
   - With PRIOR_COV_SAT_EN: S00=S11=524287, ovf=1.
   - Without it: S00=S11=0 (wrap of 2^20), ovf=1.
4. Handshake, using the setup of test 1:
   - Pulse start at cycle 3 of a run -> ignored; done still at cycle 9.
   - Hold start high on the done cycle with new P=I(1024) -> second run accepted; S=I(1024)+Q; done 9 cycles later.
5. Assert rst_n low during PH_S -> busy=0, done=0, ovf=0, p_prior_flat=0 immediately. A subsequent start runs correctly.
6. DIM=3, A=I(1024), random P and Q in [-2^14, 2^14] -> S=P+Q element-wise, done at cycle 19, ovf=0.
